// File: rtl/mmu_ram_responder_if.sv
// rtl/mmu_ram_responder_if.sv - memory bus types and core-to-bank bus interface
package mmu_ram_pkg;
   typedef enum logic [1:0] {
      MEM_ACCESS_BYTE = 2'd0,
      MEM_ACCESS_HALF = 2'd1,
      MEM_ACCESS_WORD = 2'd2
   } mem_access_t;

   // bit0 misaligned, bit1 wrong bank, bit2 out of range
   typedef logic [2:0] mem_exception_mask_t;

   localparam logic [3:0] MMU_BANK_DATA = 4'h1;
endpackage

interface mmu_ram_responder_if;
   logic [31:0]                      mem_addr;
   logic [31:0]                      mem_wr_data;
   logic                             mem_wr_ena;
   mmu_ram_pkg::mem_access_t         mem_access;
   logic [31:0]                      mem_rd_data;
   mmu_ram_pkg::mem_exception_mask_t mem_exception;

   modport master (
      output mem_addr, mem_wr_data, mem_wr_ena, mem_access,
      input  mem_rd_data, mem_exception
   );

   modport slave (
      input  mem_addr, mem_wr_data, mem_wr_ena, mem_access,
      output mem_rd_data, mem_exception
   );
endinterface

// File: rtl/mmu_ram_responder.sv
// rtl/mmu_ram_responder.sv - single RAM bank with combinational reads, masked stores and zero-fill on reset
module mmu_ram_responder
   import mmu_ram_pkg::*;
#(
   parameter int unsigned L_WORDS = 256,
   parameter logic [3:0]  BANK_ID = MMU_BANK_DATA
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic                clr_status,
   mmu_ram_responder_if.slave  bus,
   output logic                ready,
   output mem_exception_mask_t exception_flags,
   output logic [31:0]         write_count
);
   localparam int unsigned CW = (L_WORDS > 1) ? $clog2(L_WORDS) : 1;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       clr_cnt_q, clr_cnt_d;
   logic                ready_q, ready_d;
   mem_exception_mask_t flags_q, flags_d;
   logic [31:0]         count_q, count_d;

   logic [31:0] mem [L_WORDS];

   logic [25:0]         idx;
   logic [1:0]          off;
   logic [CW-1:0]       widx;
   logic [3:0]          be;
   mem_exception_mask_t exc;
   logic [31:0]         word, wdata_sh, merged, rd_data;
   logic                commit;
   logic                mem_we;
   logic [CW-1:0]       mem_wa;
   logic [31:0]         mem_wd;

   always_comb begin
      idx  = bus.mem_addr[27:2];
      off  = bus.mem_addr[1:0];
      widx = idx[CW-1:0];
      exc  = '0;
      be   = 4'b0000;
      case (bus.mem_access)
         MEM_ACCESS_BYTE: be = 4'b0001 << off;
         MEM_ACCESS_HALF: begin
            exc[0] = off[0];
            be     = 4'b0011 << off;
         end
         MEM_ACCESS_WORD: begin
            exc[0] = (off != 2'b00);
            be     = 4'b1111;
         end
         default: exc[0] = 1'b1;
      endcase
      exc[1] = (bus.mem_addr[31:28] != BANK_ID);
      exc[2] = ({6'd0, idx} >= L_WORDS);

      // Out-of-range indices never touch the array, so non-power-of-two depths stay safe.
      word = exc[2] ? 32'd0 : mem[widx];

      rd_data = 32'd0;
      case (bus.mem_access)
         MEM_ACCESS_BYTE: rd_data = {24'd0, word[{off, 3'b000} +: 8]};
         MEM_ACCESS_HALF: rd_data = {16'd0, word[{off[1], 4'b0000} +: 16]};
         MEM_ACCESS_WORD: rd_data = word;
         default:         rd_data = 32'd0;
      endcase
      if (exc != '0 || !ready_q) begin
         rd_data = 32'd0;
      end

      wdata_sh = bus.mem_wr_data << {off, 3'b000};
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = be[b] ? wdata_sh[8*b +: 8] : word[8*b +: 8];
      end

      commit = ready_q && ena && bus.mem_wr_ena && (exc == '0);

      // The clear walk owns the single write port until ready.
      mem_we = (state_q == S_CLEAR) || commit;
      mem_wa = (state_q == S_CLEAR) ? clr_cnt_q : widx;
      mem_wd = (state_q == S_CLEAR) ? 32'd0 : merged;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ready_d   = ready_q;
      flags_d   = flags_q;
      count_d   = count_q;
      case (state_q)
         S_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CW'(L_WORDS - 1)) begin
               state_d   = S_READY;
               ready_d   = 1'b1;
               clr_cnt_d = '0;
            end
         end
         S_READY: ;
         default: state_d = S_CLEAR;
      endcase
      if (commit) begin
         count_d = count_q + 32'd1;
      end
      // A faulting store in the same cycle as clr_status leaves exactly that fault recorded.
      if (ena) begin
         if (bus.mem_wr_ena && exc != '0) begin
            flags_d = clr_status ? exc : (flags_q | exc);
         end else if (clr_status) begin
            flags_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
         flags_q   <= '0;
         count_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= ready_d;
         flags_q   <= flags_d;
         count_q   <= count_d;
      end
   end

   assign bus.mem_rd_data   = rd_data;
   assign bus.mem_exception = exc;
   assign ready             = ready_q;
   assign exception_flags   = flags_q;
   assign write_count       = count_q;
endmodule
